// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite times-table responder: response codes,
// FSM state encoding, ROM address width and the product helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TT_ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_WAKE   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } rd_state_e;

    // Address is {a[2:0], b[2:0]}; 7*7 = 49 still fits in six bits.
    function automatic logic [TT_ADDR_W-1:0] tt_product(input logic [TT_ADDR_W-1:0] addr);
        return {3'b000, addr[5:3]} * {3'b000, addr[2:0]};
    endfunction

endpackage

// File: rtl/times_table_rom.sv
// One-cycle registered times-table lookup: prod = addr[5:3] * addr[2:0].
module times_table_rom
    import axi_lite_pkg::*;
(
    input  logic                 clk,
    input  logic [TT_ADDR_W-1:0] addr,
    output logic [TT_ADDR_W-1:0] prod
);

    // Register the product so the lookup behaves like a synchronous block memory.
    always_ff @(posedge clk) begin
        prod <= tt_product(addr);
    end

endmodule

// File: rtl/axi_lite_times_table_slave.sv
// AXI4-Lite read-channel responder serving a 0..7 x 0..7 times table after a
// configurable latency. One outstanding read at a time; out-of-range -> SLVERR.
module axi_lite_times_table_slave
    import axi_lite_pkg::*;
#(
    parameter int LATENCY      = 2,
    parameter bit STRICT_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        busy,
    output logic [15:0] rd_count
);

    localparam int CNT_W = 3;

    rd_state_e            state;
    rd_state_e            state_next;
    logic [CNT_W-1:0]     lat_cnt;
    logic [CNT_W-1:0]     lat_cnt_next;
    logic                 load_resp;
    logic [TT_ADDR_W-1:0] addr_q;
    logic                 err_q;
    logic [TT_ADDR_W-1:0] rom_addr;
    logic [TT_ADDR_W-1:0] rom_prod;
    logic [TT_ADDR_W-1:0] resp_prod;
    logic                 resp_err;
    logic                 ar_err;
    logic                 ar_hs;
    logic                 r_hs;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;
    logic [15:0]          rd_count_q;

    assign s_axi_arready = (state == ST_IDLE);
    assign s_axi_rvalid  = (state == ST_RESP);
    assign busy          = (state == ST_LOOKUP) || (state == ST_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign rd_count      = rd_count_q;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign ar_err = STRICT_RANGE && (s_axi_araddr[31:TT_ADDR_W] != '0);

    // The ROM sees the live address on the handshake edge so its product is
    // ready one edge later; afterwards it keeps looking up the captured address.
    assign rom_addr = ar_hs ? s_axi_araddr[TT_ADDR_W-1:0] : addr_q;

    // With LATENCY==1 the response is loaded straight from IDLE, before the ROM
    // has had an edge, so that path computes the product directly.
    assign resp_err  = (state == ST_IDLE) ? ar_err : err_q;
    assign resp_prod = (state == ST_IDLE) ? tt_product(s_axi_araddr[TT_ADDR_W-1:0]) : rom_prod;

    times_table_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .prod (rom_prod)
    );

    // State register and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_WAKE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in LOOKUP, hold in RESP until rready.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        load_resp    = 1'b0;
        case (state)
            ST_WAKE: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (ar_hs) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                        load_resp  = 1'b1;
                    end else begin
                        state_next   = ST_LOOKUP;
                        lat_cnt_next = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_LOOKUP: begin
                lat_cnt_next = lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    state_next = ST_RESP;
                    load_resp  = 1'b1;
                end
            end
            ST_RESP: begin
                if (r_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_WAKE;
            end
        endcase
    end

    // Capture the request address and range flag on the AR handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else if (ar_hs) begin
            addr_q <= s_axi_araddr[TT_ADDR_W-1:0];
            err_q  <= ar_err;
        end
    end

    // Load the response once on entry to RESP so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (load_resp) begin
            rdata_q <= resp_err ? 32'd0 : {{(32 - TT_ADDR_W){1'b0}}, resp_prod};
            rresp_q <= resp_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Count completed R handshakes, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
        end else if (r_hs) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

endmodule
